// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: host-side word FIFO feeding the UART TX core. Each stored word
// is launched as a one-cycle tx_data_valid pulse with tx_p_data held stable
// for the whole frame. Launches are paced by the core's registered tx_busy.
// A launch that tx_busy never acknowledges is re-pulsed after a timeout.
// Optional feature macro: TX_FIFO_OVF_EN adds the sticky wr_overflow output.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  tx_busy,
  output logic                  tx_data_valid,
  output logic [DATA_WIDTH-1:0] tx_p_data
`ifdef TX_FIFO_OVF_EN
  ,
  output logic                  wr_overflow
`endif
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    pop;
  logic                    wr_accept;

  // Occupancy flags derived from the registered pointers
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
            (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  end

  // Launcher next-state: pop on launch from idle, re-pulse on busy timeout
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    pdata_d = pdata_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          state_d = S_LAUNCH;
          valid_d = 1'b1;
          pdata_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
          pop     = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = S_LAUNCH;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer updates; full is judged before any same-edge pop
  always_comb begin
    wr_accept = wr_en && !full;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Control and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      pdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      pdata_q  <= pdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  assign tx_data_valid = valid_q;
  assign tx_p_data     = pdata_q;

`ifdef TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky flag for any write attempted while full
  always_comb begin
    ovf_d = ovf_q | (wr_en & full);
  end

  // Overflow register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign wr_overflow = ovf_q;
`endif

endmodule
